screen_draw_scheduler: RTL and testbench

Round-robin controller that shares the single VGA adapter write port among up to N full-screen/sprite draw engines. It grants one engine at a time, holds it enabled until the engine signals done (or a watchdog expires), and muxes and registers that engine's pixel stream onto the VGA x/y/colour/plot inputs. It acknowledges each finished request, then re-arbitrates. It sits between the game-control FSM, which raises draw requests, and the vga_adapter instance.

---
 rtl/screen_draw_scheduler_pkg.sv | 17 +
 rtl/screen_draw_scheduler_if.sv | 33 +++
 rtl/screen_draw_scheduler_rr_arbiter.sv | 28 ++
 rtl/screen_draw_scheduler.sv | 150 +++++++++++++++
 tb/tb_screen_draw_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/screen_draw_scheduler_pkg.sv
// Shared widths and FSM state encoding for the screen draw scheduler
// and anything else that talks to the VGA adapter write port.
package screen_draw_scheduler_pkg;

    localparam int unsigned VGA_X_W  = 8;
    localparam int unsigned VGA_Y_W  = 7;
    localparam int unsigned COLOUR_W = 9;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

endpackage

// File: rtl/screen_draw_scheduler_if.sv
// Engine-side request/pixel bus plus the VGA write-port outputs.
// The scheduler uses the slave modport; the environment drives master.
interface screen_draw_scheduler_if #(
    parameter int unsigned N = 4
);
    import screen_draw_scheduler_pkg::*;

    logic [N-1:0]          req;
    logic [N-1:0]          eng_valid;
    logic [N-1:0]          eng_done;
    logic [N*VGA_X_W-1:0]  eng_x;
    logic [N*VGA_Y_W-1:0]  eng_y;
    logic [N*COLOUR_W-1:0] eng_colour;
    logic [N-1:0]          eng_go;
    logic [N-1:0]          ack;
    logic                  err;
    logic                  busy;
    logic [VGA_X_W-1:0]    vga_x;
    logic [VGA_Y_W-1:0]    vga_y;
    logic [COLOUR_W-1:0]   vga_colour;
    logic                  plot;

    modport master (
        output req, eng_valid, eng_done, eng_x, eng_y, eng_colour,
        input  eng_go, ack, err, busy, vga_x, vga_y, vga_colour, plot
    );

    modport slave (
        input  req, eng_valid, eng_done, eng_x, eng_y, eng_colour,
        output eng_go, ack, err, busy, vga_x, vga_y, vga_colour, plot
    );

endinterface

// File: rtl/screen_draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: search starts at last_grant+1 (mod N)
// and the first requester found wins.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any_req
);

    logic [ID_W-1:0] cand;

    // Scan from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        grant_id = '0;
        cand     = '0;
        any_req  = |req;
        for (int unsigned k = N; k > 0; k--) begin
            cand = ID_W'((32'(last_grant) + k) % N);
            if (req[cand]) begin
                grant_id = cand;
            end
        end
    end

endmodule

// File: rtl/screen_draw_scheduler.sv
// Shares the VGA write port among N draw engines: round-robin grant,
// watchdog-bounded run, registered pixel mux, then ack/err and re-arbitrate.
module screen_draw_scheduler
    import screen_draw_scheduler_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 20000
) (
    input logic                    clk,
    input logic                    resetn,
    screen_draw_scheduler_if.slave bus
);

    localparam int unsigned ID_W = $clog2(N);
    localparam int unsigned WD_W = $clog2(TIMEOUT);

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     arb_id;
    logic                any_req;
    logic                abort;
    logic [WD_W-1:0]     wd;
    logic                timeout;
    logic [VGA_X_W-1:0]  sel_x;
    logic [VGA_Y_W-1:0]  sel_y;
    logic [COLOUR_W-1:0] sel_colour;
    logic                sel_valid;
    logic                sel_done;

    rr_arbiter #(
        .N    (N),
        .ID_W (ID_W)
    ) u_arb (
        .req        (bus.req),
        .last_grant (last_grant),
        .grant_id   (arb_id),
        .any_req    (any_req)
    );

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_valid  = 1'b0;
        sel_done   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_x      = bus.eng_x[i*VGA_X_W +: VGA_X_W];
                sel_y      = bus.eng_y[i*VGA_Y_W +: VGA_Y_W];
                sel_colour = bus.eng_colour[i*COLOUR_W +: COLOUR_W];
                sel_valid  = bus.eng_valid[i];
                sel_done   = bus.eng_done[i];
            end
        end
    end

    assign timeout = (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.eng_go = '0;
        bus.ack    = '0;
        bus.err    = 1'b0;
        bus.busy   = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                bus.eng_go[grant_id] = 1'b1;
                state_next           = S_RUN;
            end
            S_RUN: begin
                bus.eng_go[grant_id] = 1'b1;
                if (sel_done || timeout) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                bus.eng_go[grant_id] = 1'b1;
                state_next           = S_RELEASE;
            end
            S_RELEASE: begin
                if (abort) begin
                    bus.err = 1'b1;
                end else begin
                    bus.ack[grant_id] = 1'b1;
                end
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Pixel registers hold their last value outside RUN; only plot is forced low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_id       <= '0;
            last_grant     <= ID_W'(N - 1);
            abort          <= 1'b0;
            wd             <= '0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.plot       <= 1'b0;
        end else begin
            bus.plot <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_id <= arb_id;
                    end
                end
                S_GRANT: begin
                    wd    <= '0;
                    abort <= 1'b0;
                end
                S_RUN: begin
                    bus.vga_x      <= sel_x;
                    bus.vga_y      <= sel_y;
                    bus.vga_colour <= sel_colour;
                    bus.plot       <= sel_valid & ~sel_done;
                    if (wd != '1) begin
                        wd <= wd + 1'b1;
                    end
                    if (timeout) begin
                        abort <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    last_grant <= grant_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_draw_scheduler.sv
// Bench for screen_draw_scheduler: cycle-timeline reference model checked every
// cycle, plus directed literal checks; a second instance exercises the watchdog.
module tb_screen_draw_scheduler;
    import screen_draw_scheduler_pkg::*;

    localparam int N       = 4;
    localparam int TO_MAIN = 20000;
    localparam int TO_WD   = 100;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    screen_draw_scheduler_if #(.N(N)) bus ();
    screen_draw_scheduler_if #(.N(N)) wbus ();

    screen_draw_scheduler #(.N(N), .TIMEOUT(TO_MAIN)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    screen_draw_scheduler #(.N(N), .TIMEOUT(TO_WD)) dut_wd (
        .clk    (clk),
        .resetn (resetn),
        .bus    (wbus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    // Engine models and requester behaviour
    int         ecnt [N];
    int         npix [N];
    logic [N-1:0] spur_done = '0;
    logic [N-1:0] ack_seen  = '0;
    bit         auto_clear = 1'b1;

    initial forever begin
        @(posedge clk);
        #1;
        if (auto_clear) bus.req = bus.req & ~ack_seen;
        ack_seen = '0;
        for (int i = 0; i < N; i++) begin
            int   k;
            logic v;
            logic dn;
            ecnt[i] = bus.eng_go[i] ? ecnt[i] + 1 : 0;
            k  = ecnt[i] - 2;
            v  = bus.eng_go[i] && ecnt[i] >= 2 && ecnt[i] <= npix[i] + 1;
            dn = bus.eng_go[i] && ecnt[i] > npix[i] + 1;
            bus.eng_valid[i] = v;
            bus.eng_done[i]  = dn | spur_done[i];
            bus.eng_x[i*8 +: 8]      = v ? 8'(k % 160) : 8'(i * 16 + 3);
            bus.eng_y[i*7 +: 7]      = v ? 7'((k / 160) % 120) : 7'(i + 5);
            bus.eng_colour[i*9 +: 9] = !v ? 9'(i * 3 + 1) :
                                       (k == npix[i] - 1) ? 9'h1FF : 9'((k * 13 + i * 41 + 1) % 511);
        end
    end

    // Reference model: timeline of one grant (grant cycle, done cycle)
    int           cyc = 0;
    bit           m_active;
    int           m_g, m_tgrant, m_tdone, m_last;
    bit           m_abort;
    logic         m_plot;
    logic [7:0]   m_x;
    logic [6:0]   m_y;
    logic [8:0]   m_c;
    logic [N-1:0] exp_go, exp_ack;
    logic         exp_err;
    logic [N-1:0] prev_go = '0;

    int   grant_log[$];
    int   ack_cnt [N];
    int   ack_cyc [N];
    int   plot_cnt, go0_cnt, last_plot_cyc;
    logic [7:0] last_px;
    logic [6:0] last_py;
    logic [8:0] last_pc;

    initial forever begin
        bit run;
        @(negedge clk);
        cyc++;
        if (!resetn) begin
            m_active = 1'b0;
            m_last   = N - 1;
            m_plot   = 1'b0;
            m_x = '0; m_y = '0; m_c = '0;
        end
        exp_go = '0; exp_ack = '0; exp_err = 1'b0;
        if (m_active) begin
            if (m_tdone < 0 || cyc <= m_tdone + 1) exp_go[m_g] = 1'b1;
            if (m_tdone >= 0 && cyc == m_tdone + 2) begin
                if (m_abort) exp_err = 1'b1;
                else exp_ack[m_g] = 1'b1;
            end
        end
        check("eng_go",     32'(bus.eng_go),     32'(exp_go));
        check("ack",        32'(bus.ack),        32'(exp_ack));
        check("err",        32'(bus.err),        32'(exp_err));
        check("busy",       32'(bus.busy),       32'(m_active));
        check("plot",       32'(bus.plot),       32'(m_plot));
        check("vga_x",      32'(bus.vga_x),      32'(m_x));
        check("vga_y",      32'(bus.vga_y),      32'(m_y));
        check("vga_colour", 32'(bus.vga_colour), 32'(m_c));

        for (int i = 0; i < N; i++) begin
            if (bus.eng_go[i] && !prev_go[i]) grant_log.push_back(i);
            if (bus.ack[i]) begin
                ack_cnt[i]++;
                ack_cyc[i] = cyc;
            end
        end
        prev_go  = bus.eng_go;
        ack_seen = ack_seen | bus.ack;
        if (bus.eng_go[0]) go0_cnt++;
        if (bus.plot) begin
            plot_cnt++;
            last_plot_cyc = cyc;
            last_px = bus.vga_x; last_py = bus.vga_y; last_pc = bus.vga_colour;
        end

        if (resetn) begin
            if (m_active && m_tdone < 0 && cyc >= m_tgrant + 1) begin
                bit expired;
                expired = (cyc - (m_tgrant + 1) == TO_MAIN - 1);
                if (bus.eng_done[m_g] || expired) begin
                    m_tdone = cyc;
                    m_abort = expired;
                end
            end
            run = m_active && cyc >= m_tgrant + 1 && (m_tdone < 0 || cyc <= m_tdone);
            if (run) begin
                m_plot = bus.eng_valid[m_g] & ~bus.eng_done[m_g];
                m_x = bus.eng_x[m_g*8 +: 8];
                m_y = bus.eng_y[m_g*7 +: 7];
                m_c = bus.eng_colour[m_g*9 +: 9];
            end else begin
                m_plot = 1'b0;
            end
            if (m_active && m_tdone >= 0 && cyc == m_tdone + 2) begin
                m_last   = m_g;
                m_active = 1'b0;
            end else if (!m_active && bus.req != '0) begin
                m_g      = rr_pick(m_last, bus.req);
                m_tgrant = cyc + 1;
                m_tdone  = -1;
                m_abort  = 1'b0;
                m_active = 1'b1;
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while ((bus.req != '0 || bus.busy) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_completes"}, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_go(input int idx, input int budget, input string name);
        int k = 0;
        while (!bus.eng_go[idx] && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_granted"}, 32'(k < budget), 32'd1);
    endtask

    task automatic clear_stats();
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            ack_cnt[i] = 0;
            ack_cyc[i] = 0;
        end
        plot_cnt = 0;
        go0_cnt  = 0;
    endtask

    // Watchdog instance: engine 1 never finishes and never emits pixels
    bit wd_done = 1'b0;
    initial begin
        int wc = 0, g_cyc = -1, err_cyc = -1, err_cnt = 0, wd_ack = 0, go_cnt = 0, wplot = 0;
        logic [N-1:0] go_at_err = '1;
        logic [N-1:0] wprev = '0;
        wbus.req = '0; wbus.eng_valid = '0; wbus.eng_done = '0;
        wbus.eng_x = '0; wbus.eng_y = '0; wbus.eng_colour = '0;
        wait (resetn);
        @(posedge clk);
        #1;
        wbus.req = 4'b0010;
        while (wc < 400 && !(err_cnt > 0 && wc > err_cyc + 3)) begin
            @(negedge clk);
            wc++;
            if (wbus.eng_go[1]) go_cnt++;
            if (wbus.eng_go[1] && !wprev[1]) g_cyc = wc;
            wprev = wbus.eng_go;
            if (wbus.ack != '0) wd_ack++;
            if (wbus.plot) wplot++;
            if (wbus.err) begin
                err_cnt++;
                err_cyc   = wc;
                go_at_err = wbus.eng_go;
                wbus.req  = '0;
            end
        end
        check("wd_err_pulses",   32'(err_cnt), 32'd1);
        check("wd_no_ack",       32'(wd_ack),  32'd0);
        check("wd_err_latency",  32'(err_cyc - g_cyc), 32'd102);
        check("wd_go_cycles",    32'(go_cnt),  32'd102);
        check("wd_go_low_at_err", 32'(go_at_err), 32'd0);
        check("wd_no_plot",      32'(wplot),   32'd0);
        check("wd_idle_after",   32'(wbus.busy), 32'd0);
        wd_done = 1'b1;
    end

    initial begin
        int req_cyc;
        int k;
        bus.req = '0; bus.eng_valid = '0; bus.eng_done = '0;
        bus.eng_x = '0; bus.eng_y = '0; bus.eng_colour = '0;
        for (int i = 0; i < N; i++) begin
            npix[i] = 10;
            ecnt[i] = 0;
        end
        clear_stats();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("reset_busy",   32'(bus.busy),   32'd0);
        check("reset_eng_go", 32'(bus.eng_go), 32'd0);
        check("reset_plot",   32'(bus.plot),   32'd0);

        // Round-robin fairness with all requests held
        auto_clear = 1'b0;
        bus.req = 4'b1111;
        k = 0;
        while (grant_log.size() < 5 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        bus.req = '0;
        wait_idle(200, "rr");
        check("rr_grants", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() >= 5) begin
            check("rr_order0", 32'(grant_log[0]), 32'd0);
            check("rr_order1", 32'(grant_log[1]), 32'd1);
            check("rr_order2", 32'(grant_log[2]), 32'd2);
            check("rr_order3", 32'(grant_log[3]), 32'd3);
            check("rr_order4", 32'(grant_log[4]), 32'd0);
        end
        check("rr_ack0", 32'(ack_cnt[0]), 32'd2);
        check("rr_ack1", 32'(ack_cnt[1]), 32'd1);
        check("rr_ack3", 32'(ack_cnt[3]), 32'd1);

        // Single full-screen draw by engine 0; other engines' done flags are noise
        auto_clear = 1'b1;
        clear_stats();
        npix[0]   = 19200;
        spur_done = 4'b1110;
        @(posedge clk);
        #1;
        bus.req = 4'b0001;
        req_cyc = cyc + 1;
        wait_idle(20000, "single");
        spur_done = '0;
        npix[0]   = 10;
        check("single_plot_cycles", 32'(plot_cnt), 32'd19200);
        check("single_go_cycles",   32'(go0_cnt),  32'd19203);
        check("single_req_to_ack",  32'(ack_cyc[0] - req_cyc), 32'd19204);
        check("single_ack_count",   32'(ack_cnt[0]), 32'd1);
        check("single_tail_to_ack", 32'(ack_cyc[0] - last_plot_cyc), 32'd2);
        check("last_pixel_x",       32'(last_px), 32'd159);
        check("last_pixel_y",       32'(last_py), 32'd119);
        check("last_pixel_colour",  32'(last_pc), 32'h1FF);

        // Reset in the middle of engine 2's run
        npix[2] = 50;
        bus.req = 4'b0100;
        wait_go(2, 50, "rst_pre");
        repeat (6) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("rst_eng_go",     32'(bus.eng_go),     32'd0);
        check("rst_ack",        32'(bus.ack),        32'd0);
        check("rst_err",        32'(bus.err),        32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_plot",       32'(bus.plot),       32'd0);
        check("rst_vga_x",      32'(bus.vga_x),      32'd0);
        check("rst_vga_y",      32'(bus.vga_y),      32'd0);
        check("rst_vga_colour", 32'(bus.vga_colour), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clear_stats();
        bus.req = 4'b0101;
        resetn  = 1'b1;
        wait_idle(400, "rst_post");
        check("rst_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            check("rst_first_grant",  32'(grant_log[0]), 32'd0);
            check("rst_second_grant", 32'(grant_log[1]), 32'd2);
        end

        // Request withdrawn mid-run still completes and is acknowledged
        clear_stats();
        bus.req = 4'b1000;
        wait_go(3, 50, "drop");
        repeat (4) @(posedge clk);
        #1;
        bus.req[3] = 1'b0;
        wait_idle(200, "drop");
        check("drop_ack3", 32'(ack_cnt[3]), 32'd1);
        check("drop_plot_cycles", 32'(plot_cnt), 32'd10);

        k = 0;
        while (!wd_done && k < 1000) begin
            @(posedge clk);
            k++;
        end
        check("wd_test_finished", 32'(wd_done), 32'd1);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
